dispscan: RTL and testbench

DISPSCAN -- requirements
Module: dispscan

---
 rtl/dispscan.sv | 111 +++++++++++
 tb/tb_dispscan.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dispscan.sv
// Four-digit multiplexed 7-segment scanner with frame snapshot, leading-zero
// blanking and frame-counted digit blinking. All outputs are registered.
module dispscan #(
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [15:0] dig,
  input  logic [3:0]  dp_in,
  input  logic        blink_en,
  input  logic [3:0]  blink_mask,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [7:0] LastFrame = 8'(BLINK_FRAMES - 1);
  localparam logic [6:0] SegBlank  = 7'h7F;

  logic [1:0]  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic [3:0]  snapDp_q, snapDp_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        bph_q, bph_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        wrap;
  logic [3:0]  curDigit;
  logic        blank;

  function automatic logic [6:0] bcdToSeg(input logic [3:0] value);
    logic [6:0] s;
    case (value)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Snapshot and frame counter advance only at the 3->0 wrap so a frame never tears.
  always_comb begin
    wrap     = scan_en && (idx_q == 2'd3);
    idx_d    = scan_en ? idx_q + 2'd1 : idx_q;
    snap_d   = wrap ? dig : snap_q;
    snapDp_d = wrap ? dp_in : snapDp_q;
    fcnt_d   = fcnt_q;
    bph_d    = bph_q;
    if (wrap) begin
      if (fcnt_q == LastFrame) begin
        fcnt_d = 8'd0;
        bph_d  = ~bph_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Output stage works from the pre-edge index, hence the one-clock lag behind idx.
  always_comb begin
    curDigit = snap_q[{idx_q, 2'b00} +: 4];
    blank    = (blink_en && blink_mask[idx_q] && !bph_q)
            || (lzb && (idx_q == 2'd3) && (snap_q[15:12] == 4'd0));
    an_d     = ~(4'b0001 << idx_q);
    seg_d    = bcdToSeg(curDigit);
    dp_d     = ~snapDp_q[idx_q];
    if (blank) begin
      seg_d = SegBlank;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= 2'd0;
      snap_q   <= 16'd0;
      snapDp_q <= 4'd0;
      fcnt_q   <= 8'd0;
      bph_q    <= 1'b1;
      an_q     <= 4'b1111;
      seg_q    <= SegBlank;
      dp_q     <= 1'b1;
    end else begin
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      snapDp_q <= snapDp_d;
      fcnt_q   <= fcnt_d;
      bph_q    <= bph_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_dispscan.sv
// Directed bench for dispscan: per-clock vector table plus hand sequences
// for mid-frame reset and blink phase timing (BLINK_FRAMES = 2).
module tb_dispscan;

  typedef struct {
    logic        rst;
    logic        scanEn;
    logic [15:0] dig;
    logic [3:0]  dpIn;
    logic        blinkEn;
    logic [3:0]  blinkMask;
    logic        lzb;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [15:0] dig;
  logic [3:0]  dp_in;
  logic        blink_en;
  logic [3:0]  blink_mask;
  logic        lzb;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  vector_t table_v[14];

  dispscan #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .dig(dig), .dp_in(dp_in),
    .blink_en(blink_en), .blink_mask(blink_mask), .lzb(lzb),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic vector_t mk(input logic r, input logic s, input logic [15:0] d,
                                 input logic [3:0] dpi, input logic be, input logic [3:0] bm,
                                 input logic lz, input logic [3:0] ea, input logic [6:0] es,
                                 input logic ed);
    vector_t v;
    v.rst = r; v.scanEn = s; v.dig = d; v.dpIn = dpi; v.blinkEn = be;
    v.blinkMask = bm; v.lzb = lz; v.expAn = ea; v.expSeg = es; v.expDp = ed;
    return v;
  endfunction

  // Drive on the falling edge so the rising edge sees stable inputs.
  task automatic applyStimulus(input vector_t v);
    @(negedge clk);
    rst        = v.rst;
    scan_en    = v.scanEn;
    dig        = v.dig;
    dp_in      = v.dpIn;
    blink_en   = v.blinkEn;
    blink_mask = v.blinkMask;
    lzb        = v.lzb;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vector_t v);
    checks++;
    if (an !== v.expAn || seg !== v.expSeg || dp !== v.expDp) begin
      errors++;
      $display("[TB] FAIL %s: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, an, seg, dp, v.expAn, v.expSeg, v.expDp);
    end
  endtask

  function automatic logic [6:0] expSegOf(input logic [3:0] d);
    logic [6:0] lut [10];
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d > 4'd9) ? 7'h3F : lut[d];
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vector_t v;
    logic [15:0] blinkDig;
    rst = 1'b1; scan_en = 1'b0; dig = '0; dp_in = '0;
    blink_en = 1'b0; blink_mask = '0; lzb = 1'b0;

    // Reset, idle, one frame to load 1259, display it, then 0A07 with lzb.
    table_v[0]  = mk(1, 1, 16'h0000, 4'b0000, 0, 4'b0000, 0, 4'b1111, 7'h7F, 1);
    table_v[1]  = mk(0, 0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 4'b1110, 7'h40, 1);
    table_v[2]  = mk(0, 1, 16'h1259, 4'b0100, 0, 4'b0000, 0, 4'b1110, 7'h40, 1);
    table_v[3]  = mk(0, 1, 16'h1259, 4'b0100, 0, 4'b0000, 0, 4'b1101, 7'h40, 1);
    table_v[4]  = mk(0, 1, 16'h1259, 4'b0100, 0, 4'b0000, 0, 4'b1011, 7'h40, 1);
    table_v[5]  = mk(0, 1, 16'h1259, 4'b0100, 0, 4'b0000, 0, 4'b0111, 7'h40, 1);
    table_v[6]  = mk(0, 1, 16'h1259, 4'b0100, 0, 4'b0000, 0, 4'b1110, 7'h10, 1);
    table_v[7]  = mk(0, 1, 16'h1259, 4'b0100, 0, 4'b0000, 0, 4'b1101, 7'h12, 1);
    table_v[8]  = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1011, 7'h24, 0);
    table_v[9]  = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b0111, 7'h79, 1);
    table_v[10] = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1110, 7'h78, 1);
    table_v[11] = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1101, 7'h40, 1);
    table_v[12] = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1011, 7'h3F, 0);
    table_v[13] = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b0111, 7'h7F, 1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(table_v[i]);
      checkOutput($sformatf("vec%0d", i), table_v[i]);
    end

    // Reset in the middle of a frame (idx=2) discards it; snapshot returns to zero.
    v = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1110, 7'h78, 1);
    applyStimulus(v); checkOutput("midA", v);
    v = mk(0, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1101, 7'h40, 1);
    applyStimulus(v); checkOutput("midB", v);
    v = mk(1, 1, 16'h0A07, 4'b0100, 0, 4'b0000, 1, 4'b1111, 7'h7F, 1);
    applyStimulus(v); checkOutput("midRst", v);
    v = mk(0, 0, 16'h0A07, 4'b0100, 0, 4'b0000, 0, 4'b1110, 7'h40, 1);
    applyStimulus(v); checkOutput("midRelease", v);

    // Blink: reset (scan_en high must be ignored), then continuous scanning.
    blinkDig = 16'h1234;
    v = mk(1, 1, blinkDig, 4'b0000, 1, 4'b0011, 0, 4'b1111, 7'h7F, 1);
    applyStimulus(v); checkOutput("blinkRst", v);
    for (int n = 0; n < 32; n++) begin
      int frame;
      int pos;
      logic [3:0] d;
      frame = n / 4;
      pos   = n % 4;
      d     = (frame == 0) ? 4'd0 : blinkDig[pos*4 +: 4];
      v = mk(0, 1, blinkDig, 4'b0000, 1, 4'b0011, 0,
             ~(4'b0001 << pos), expSegOf(d), 1);
      if ((frame % 4) >= 2 && pos <= 1) v.expSeg = 7'h7F;
      applyStimulus(v);
      checkOutput($sformatf("blink_f%0d_d%0d", frame, pos), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
